// File: rtl/prog_seq_if.sv
// Host/CPU-facing signal bundle of the program sequencer.
// The slave side is the sequencer; the master side is the host that loads code and acknowledges instructions.
interface prog_seq_if #(
  parameter int IRW  = 32,
  parameter int AW   = 4,
  parameter int PSRW = 5
) ();
  logic            ld_en;
  logic [AW-1:0]   ld_addr;
  logic [IRW-1:0]  ld_data;
  logic            start;
  logic            done;
  logic [PSRW-1:0] psr;
  logic [IRW-1:0]  ireg;
  logic            issue;
  logic [AW-1:0]   pc;
  logic            busy;
  logic            halted;
  logic            err;

  modport master (
    output ld_en, ld_addr, ld_data, start, done, psr,
    input  ireg, issue, pc, busy, halted, err
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, start, done, psr,
    output ireg, issue, pc, busy, halted, err
  );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: fetches instructions from a small loadable memory, resolves branches and halts
// locally, and hands data-path ops to an external CPU, waiting for its done pulse with a timeout.
module prog_seq #(
  parameter int IRW  = 32,
  parameter int AW   = 4,
  parameter int PSRW = 5,
  parameter int TMO  = 15
) (
  input  logic      clk,
  input  logic      rst,
  prog_seq_if.slave bus
);

  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_BRA = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_ROT = 4'd6;
  localparam logic [3:0] OP_SHF = 4'd7;
  localparam logic [3:0] OP_HLT = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam int PSR_Z = 4;
  localparam int PSR_N = 3;
  localparam int PSR_C = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IRW-1:0]  mem [2**AW];
  logic [AW-1:0]   pc;
  logic [AW-1:0]   pc_next;
  logic [AW-1:0]   pc_inc;
  logic [IRW-1:0]  ireg;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_inc;
  logic            halted;
  logic            err;
  logic [PSRW-1:0] psr;
  logic [3:0]      op;
  logic [1:0]      cc;
  logic [AW-1:0]   dst_addr;

  logic mem_we;
  logic ireg_ld;
  logic timer_clr;
  logic timer_en;
  logic set_halt;
  logic set_err;
  logic clr_halt;
  logic issue;
  logic unused_psr;

  function automatic logic cc_taken(input logic [1:0] code, input logic [PSRW-1:0] flags);
    case (code)
      2'b00:   cc_taken = 1'b1;
      2'b01:   cc_taken = flags[PSR_C];
      2'b10:   cc_taken = flags[PSR_Z];
      default: cc_taken = flags[PSR_N];
    endcase
  endfunction

  assign psr        = bus.psr;
  assign unused_psr = ^psr[2:1];
  assign op         = ireg[IRW-1 -: 4];
  assign cc         = ireg[IRW-7 -: 2];
  assign dst_addr   = ireg[AW-1:0];
  assign pc_inc     = pc + 1'b1;
  assign timer_inc  = timer + 1'b1;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    mem_we     = 1'b0;
    ireg_ld    = 1'b0;
    timer_clr  = 1'b0;
    timer_en   = 1'b0;
    set_halt   = 1'b0;
    set_err    = 1'b0;
    clr_halt   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ld_en) begin
          mem_we = 1'b1;
        end else if (bus.start) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        ireg_ld    = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        case (op)
          OP_HLT: begin
            set_halt   = 1'b1;
            state_next = HALT;
          end
          OP_BRA: begin
            pc_next    = cc_taken(cc, psr) ? dst_addr : pc_inc;
            state_next = FETCH;
          end
          OP_LD, OP_STR, OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: begin
            issue      = 1'b1;
            timer_clr  = 1'b1;
            state_next = WAIT;
          end
          OP_NOP: begin
            pc_next    = pc_inc;
            state_next = FETCH;
          end
          default: begin
            pc_next    = pc_inc;
            state_next = FETCH;
          end
        endcase
      end
      WAIT: begin
        // done wins over a timeout landing in the same cycle; timeout fires on the cycle
        // whose increment would bring the timer to TMO, i.e. TMO cycles after entering WAIT
        if (bus.done) begin
          pc_next    = pc_inc;
          state_next = FETCH;
        end else if (timer_inc == TW'(TMO)) begin
          timer_en   = 1'b1;
          set_halt   = 1'b1;
          set_err    = 1'b1;
          state_next = HALT;
        end else begin
          timer_en = 1'b1;
        end
      end
      HALT: begin
        if (bus.start) begin
          clr_halt   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ireg   <= '0;
      timer  <= '0;
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      pc <= pc_next;
      if (ireg_ld) begin
        ireg <= mem[pc];
      end
      if (timer_clr) begin
        timer <= '0;
      end else if (timer_en) begin
        timer <= timer_inc;
      end
      if (set_halt) begin
        halted <= 1'b1;
      end
      if (set_err) begin
        err <= 1'b1;
      end
      if (clr_halt) begin
        halted <= 1'b0;
        err    <= 1'b0;
      end
    end
  end

  // Program memory survives reset; only writes are held off while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  assign bus.ireg   = ireg;
  assign bus.issue  = issue;
  assign bus.pc     = pc;
  assign bus.busy   = (state == FETCH) || (state == ISSUE) || (state == WAIT);
  assign bus.halted = halted;
  assign bus.err    = err;

endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: single-instruction vector table plus hand sequences for timeout, wrap and reset.
module tb_prog_seq;
  localparam int IRW  = 32;
  localparam int AW   = 4;
  localparam int PSRW = 5;
  localparam int TMO  = 15;
  localparam int NV   = 19;
  localparam logic [31:0] HLT_W = 32'h8000_0000;
  localparam logic [31:0] ADD_W = 32'h5000_1002;
  localparam logic [31:0] NOP_W = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  psr;
    logic [3:0]  pc;
    logic        iss;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_seq_if #(.IRW(IRW), .AW(AW), .PSRW(PSRW)) bus ();

  prog_seq #(.IRW(IRW), .AW(AW), .PSRW(PSRW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passed = 0;
  int total  = 0;
  int issues = 0;
  int cnt    = 0;
  int done_dly = 3;
  bit auto_done = 1'b1;
  logic [31:0] exp_q [$];
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock; samples 1 time unit after the edge, scores issue pulses and models the CPU's done.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    bus.done = 1'b0;
    if (bus.issue) begin
      issues++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL issue_unexpected: got issue with ireg 0x%0h expected no issue", bus.ireg);
      end else begin
        e = exp_q.pop_front();
        check("issue_ireg", bus.ireg, e);
      end
      if (auto_done) cnt = done_dly;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) bus.done = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ld_en = 1'b0;
    bus.done  = 1'b0;
    cnt = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    step();
    bus.ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_to_halt(input string name);
    for (int i = 0; i < 200 && !bus.halted; i++) step();
    check({name, "_halted"}, 32'(bus.halted), 32'd1);
  endtask

  task automatic wait_issue(input string name);
    for (int i = 0; i < 20 && !bus.issue; i++) step();
    check({name, "_issue_seen"}, 32'(bus.issue), 32'd1);
  endtask

  initial begin
    logic busy_all;
    logic wrapped;
    logic [3:0] prev;

    vecs[0]  = '{ADD_W,        5'b00000, 4'd1, 1'b1};
    vecs[1]  = '{NOP_W,        5'b00000, 4'd1, 1'b0};
    vecs[2]  = '{32'hA000_0000, 5'b00000, 4'd1, 1'b0};
    vecs[3]  = '{32'hF123_4567, 5'b00000, 4'd1, 1'b0};
    vecs[4]  = '{32'h3000_0007, 5'b00000, 4'd7, 1'b0};
    vecs[5]  = '{32'h3100_0009, 5'b00001, 4'd9, 1'b0};
    vecs[6]  = '{32'h3100_0009, 5'b11110, 4'd1, 1'b0};
    vecs[7]  = '{32'h3200_0005, 5'b10000, 4'd5, 1'b0};
    vecs[8]  = '{32'h3200_0005, 5'b00000, 4'd1, 1'b0};
    vecs[9]  = '{32'h3300_0003, 5'b01000, 4'd3, 1'b0};
    vecs[10] = '{32'h3300_0003, 5'b10111, 4'd1, 1'b0};
    vecs[11] = '{32'h3000_00F3, 5'b00000, 4'd3, 1'b0};
    vecs[12] = '{32'h1000_0000, 5'b00000, 4'd1, 1'b1};
    vecs[13] = '{32'h2000_0000, 5'b00000, 4'd1, 1'b1};
    vecs[14] = '{32'h4000_0000, 5'b00000, 4'd1, 1'b1};
    vecs[15] = '{32'h6000_0000, 5'b00000, 4'd1, 1'b1};
    vecs[16] = '{32'h7000_0000, 5'b00000, 4'd1, 1'b1};
    vecs[17] = '{32'h9000_0000, 5'b00000, 4'd1, 1'b1};
    vecs[18] = '{HLT_W,        5'b00000, 4'd0, 1'b0};

    rst = 1'b1;
    bus.ld_en = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.start = 1'b0;
    bus.done = 1'b0;
    bus.psr = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_pc",     32'(bus.pc),     32'd0);
    check("rst_ireg",   bus.ireg,        32'd0);
    check("rst_issue",  32'(bus.issue),  32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_err",    32'(bus.err),    32'd0);

    bus.done = 1'b1;
    step();
    check("idle_done_busy", 32'(bus.busy), 32'd0);
    check("idle_done_pc",   32'(bus.pc),   32'd0);

    bus.start = 1'b1;
    load(4'd0, HLT_W);
    bus.start = 1'b0;
    step();
    check("start_with_ld_busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      bus.psr = vecs[v].psr;
      for (int a = 0; a < 16; a++) load(a[3:0], (a == 0) ? vecs[v].instr : HLT_W);
      issues = 0;
      if (vecs[v].iss) exp_q.push_back(vecs[v].instr);
      pulse_start();
      run_to_halt($sformatf("vec%0d", v));
      check($sformatf("vec%0d_pc", v),     32'(bus.pc),  32'(vecs[v].pc));
      check($sformatf("vec%0d_issues", v), 32'(issues),  32'(vecs[v].iss));
      check($sformatf("vec%0d_err", v),    32'(bus.err), 32'd0);
      check($sformatf("vec%0d_busy", v),   32'(bus.busy), 32'd0);
    end
    bus.psr = '0;

    pulse_start();
    check("halt_start_halted", 32'(bus.halted), 32'd0);
    check("halt_start_err",    32'(bus.err),    32'd0);
    check("halt_start_busy",   32'(bus.busy),   32'd0);

    // Timeout with done withheld.
    do_reset();
    load(4'd0, ADD_W);
    load(4'd1, HLT_W);
    auto_done = 1'b0;
    exp_q.push_back(ADD_W);
    pulse_start();
    wait_issue("tmo");
    step();
    repeat (TMO - 1) step();
    check("tmo_before_halted", 32'(bus.halted), 32'd0);
    check("tmo_before_busy",   32'(bus.busy),   32'd1);
    step();
    check("tmo_halted", 32'(bus.halted), 32'd1);
    check("tmo_err",    32'(bus.err),    32'd1);
    check("tmo_pc",     32'(bus.pc),     32'd0);

    // done in the timeout cycle wins.
    do_reset();
    exp_q.push_back(ADD_W);
    pulse_start();
    wait_issue("tmo_race");
    step();
    repeat (TMO - 1) step();
    bus.done = 1'b1;
    step();
    check("tmo_race_err",  32'(bus.err),  32'd0);
    check("tmo_race_pc",   32'(bus.pc),   32'd1);
    check("tmo_race_busy", 32'(bus.busy), 32'd1);
    auto_done = 1'b1;
    run_to_halt("tmo_race");
    check("tmo_race_end_err", 32'(bus.err), 32'd0);

    // Sixteen NOPs: pc wraps and the sequencer never leaves the busy states.
    do_reset();
    for (int a = 0; a < 16; a++) load(a[3:0], NOP_W);
    issues = 0;
    pulse_start();
    busy_all = 1'b1;
    wrapped = 1'b0;
    prev = bus.pc;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bus.busy) busy_all = 1'b0;
      if (prev == 4'd15 && bus.pc == 4'd0) wrapped = 1'b1;
      prev = bus.pc;
    end
    check("wrap_seen",   32'(wrapped),  32'd1);
    check("wrap_busy",   32'(busy_all), 32'd1);
    check("wrap_issues", 32'(issues),   32'd0);

    // Reset in the middle of WAIT, then rerun from retained memory.
    do_reset();
    load(4'd0, ADD_W);
    load(4'd1, HLT_W);
    auto_done = 1'b0;
    exp_q.push_back(ADD_W);
    pulse_start();
    wait_issue("rstw");
    step();
    step();
    check("rstw_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_pc",     32'(bus.pc),     32'd0);
    check("rstw_ireg",   bus.ireg,        32'd0);
    check("rstw_issue",  32'(bus.issue),  32'd0);
    check("rstw_busy",   32'(bus.busy),   32'd0);
    check("rstw_halted", 32'(bus.halted), 32'd0);
    check("rstw_err",    32'(bus.err),    32'd0);
    auto_done = 1'b1;
    exp_q.push_back(ADD_W);
    pulse_start();
    run_to_halt("rstw_rerun");
    check("rstw_rerun_pc",  32'(bus.pc),  32'd1);
    check("rstw_rerun_err", 32'(bus.err), 32'd0);

    // Loads attempted during WAIT must not land.
    do_reset();
    load(4'd0, ADD_W);
    load(4'd1, HLT_W);
    load(4'd2, HLT_W);
    auto_done = 1'b0;
    exp_q.push_back(ADD_W);
    pulse_start();
    wait_issue("ldw");
    step();
    bus.ld_en = 1'b1;
    bus.ld_addr = 4'd1;
    bus.ld_data = NOP_W;
    step();
    step();
    bus.ld_en = 1'b0;
    bus.done = 1'b1;
    step();
    auto_done = 1'b1;
    run_to_halt("ldw");
    check("ldw_pc", 32'(bus.pc), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/prog_seq.md
PROG_SEQ -- requirements
Module: prog_seq

Interface
REQ-001 SHALL have parameter IRW, default 32, instruction register width.
REQ-002 SHALL have parameter AW, default 4, program address width (16 entries).
REQ-003 SHALL have parameter PSRW, default 5, PSR width, bits {zero,negative,even,parity,carry} = [4:0].
REQ-004 SHALL have parameter TMO, default 15, max WAIT cycles before timeout.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ld_en  input  1  program-memory write strobe.
REQ-008 SHALL have port ld_addr  input  AW  write address.
REQ-009 SHALL have port ld_data  input  IRW  instruction word to write.
REQ-010 SHALL have port start  input  1  begin execution at address 0, or clear HALT.
REQ-011 SHALL have port done  input  1  cpu result-valid, one pulse per executed instruction.
REQ-012 SHALL have port psr  input  PSRW  current cpu status flags.
REQ-013 SHALL have port ireg  output  IRW  instruction presented to cpu.
REQ-014 SHALL have port issue  output  1  ireg valid for cpu this cycle.
REQ-015 SHALL have port pc  output  AW  current program counter.
REQ-016 SHALL have ports busy, halted, err  output  1 each  status flags.

Function
REQ-017 SHALL decode ireg fields as: op [31:28], srctype [27], dsttype [26], cc [25:24], src [23:12], dst [11:0].
REQ-018 SHALL use opcodes NOP=0, LD=1, STR=2, BRA=3, XOR=4, ADD=5, ROT=6, SHF=7, HLT=8, CMP=9; values 10-15 SHALL execute as NOP.
REQ-019 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, HALT.
REQ-020 SHALL, in IDLE, write mem[ld_addr] <= ld_data when ld_en; ld_en in any other state SHALL be ignored.
REQ-021 SHALL, in IDLE with start=1 and ld_en=0, set pc <= 0 and go to FETCH; start with ld_en=1 SHALL perform the write only.
REQ-022 SHALL, in FETCH, load ireg <= mem[pc] and go to ISSUE (one-cycle fetch latency).
REQ-023 SHALL, in ISSUE, for HLT set halted=1 and go to HALT, pc unchanged.
REQ-024 SHALL, in ISSUE, for NOP or undefined op set pc <= pc+1 and go to FETCH; issue stays 0.
REQ-025 SHALL, in ISSUE, for BRA evaluate cc (00 always, 01 carry, 10 zero, 11 negative) against psr, then set pc <= dst[AW-1:0] if taken else pc+1, and go to FETCH; issue stays 0.
REQ-026 SHALL, in ISSUE, for ops 1,2,4-7,9 drive issue=1 for exactly that cycle, clear the timer and go to WAIT.
REQ-027 SHALL hold ireg stable from FETCH exit until the next FETCH.
REQ-028 SHALL, in WAIT, on done=1 set pc <= pc+1 and go to FETCH.
REQ-029 SHALL, in WAIT without done, increment the timer; when timer==TMO it SHALL set err=1 and halted=1 and go to HALT.
REQ-030 SHALL give done priority when done and timeout coincide.
REQ-031 SHALL ignore done in every state except WAIT.
REQ-032 SHALL compute pc+1 modulo 2^AW (15 wraps to 0).
REQ-033 SHALL, in HALT, on start=1 clear halted and err and go to IDLE; program memory is retained.
REQ-034 SHALL drive busy=1 in FETCH, ISSUE and WAIT; otherwise 0.

Reset
REQ-035 SHALL, when rst=1, force state IDLE, pc=0, ireg=0, timer=0, issue=0, busy=0, halted=0, err=0, with rst taking priority over all other inputs including mid-WAIT.
REQ-036 SHALL NOT clear program memory on reset.

Verification
REQ-037 SHALL test: load mem[0]=ADD (0x5000_1002), mem[1]=HLT (0x8000_0000), start, done 3 cycles after issue -> exactly one issue pulse with ireg=0x5000_1002, pc=1, halted=1, err=0.
REQ-038 SHALL test: mem[0]=BRA cc=10 dst=5 with psr zero=1 -> pc=5 and no issue; repeat with psr=0 -> pc=1.
REQ-039 SHALL test: issue with done withheld -> err=1 and halted=1 exactly TMO cycles after WAIT entry; done arriving in that same cycle -> no err, pc advances.
REQ-040 SHALL test: program of 16 NOPs -> pc wraps 15->0 and busy stays 1.
REQ-041 SHALL test: rst asserted mid-WAIT -> all outputs at reset values next cycle, memory contents intact after restart.
REQ-042 SHALL test: ld_en during WAIT -> memory unchanged; done pulse while IDLE -> no state change.
